// File: rtl/reg_view_disp.sv
// rtl/reg_view_disp.sv - register-bank viewer driving a multiplexed seven-segment display
// Optional feature: define REG_VIEW_ADDR_SHOW_EN to show rd_addr on the top two digits.
module reg_view_disp #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              mode,
    input  logic [ADDR_W-1:0] sel,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [6:0]        SEG,
    output logic [DIGITS-1:0] AN,
    output logic              DP
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [HW-1:0]     dwell_q, dwell_d;
    logic [31:0]       shadow_q;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;
    logic [3:0]        nib;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Manual mode holds the dwell counter at zero, so entering auto always starts a fresh dwell.
    always_comb begin
        rd_addr_d = sel;
        dwell_d   = '0;
        if (mode) begin
            rd_addr_d = rd_addr_q;
            if (dwell_q == HW'(HOLD_CYCLES - 1)) begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
            end else begin
                dwell_d = dwell_q + HW'(1);
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        digit_d   = digit_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end
    end

`ifdef REG_VIEW_ADDR_SHOW_EN
    logic [7:0] addr_ext;
    assign addr_ext = 8'(rd_addr_q);
`endif

    always_comb begin
        nib  = 4'h0;
        dp_d = !((digit_q == '0) && mode);
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                nib = shadow_q[4*i +: 4];
            end
        end
`ifdef REG_VIEW_ADDR_SHOW_EN
        if (DIGITS >= 4) begin
            if (digit_q == DW'(DIGITS - 1)) begin
                nib = addr_ext[7:4];
            end else if (digit_q == DW'(DIGITS - 2)) begin
                nib  = addr_ext[3:0];
                dp_d = 1'b0;
            end
        end
`endif
        seg_d = hex_seg(nib);
    end

    always_comb begin
        an_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = !(digit_q == DW'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            rd_addr_q <= '0;
            dwell_q   <= '0;
            shadow_q  <= '0;
            refresh_q <= '0;
            digit_q   <= '0;
            seg_q     <= 7'b1111111;
            an_q      <= '1;
            dp_q      <= 1'b1;
        end else begin
            rd_addr_q <= rd_addr_d;
            dwell_q   <= dwell_d;
            shadow_q  <= rd_data;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign SEG     = seg_q;
    assign AN      = an_q;
    assign DP      = dp_q;

endmodule

// File: tb/tb_reg_view_disp.sv
// tb/tb_reg_view_disp.sv - self-checking bench for reg_view_disp with a time-based reference model
// Define REG_VIEW_ADDR_SHOW_EN to also exercise the address-display digits.
module tb_reg_view_disp;
    localparam int DIGITS      = 8;
    localparam int REFRESH_DIV = 4;
    localparam int ADDR_W      = 4;
    localparam int HOLD_CYCLES = 16;
    localparam int HMAX        = 4096;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] rd_data;
    logic [3:0]  rd_addr;
    logic [6:0]  SEG;
    logic [7:0]  AN;
    logic        DP;

    logic [31:0] bank [0:15];
    assign rd_data = bank[rd_addr];

    reg_view_disp #(
        .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .CLK(CLK), .rst(rst), .mode(mode), .sel(sel), .rd_data(rd_data),
        .rd_addr(rd_addr), .SEG(SEG), .AN(AN), .DP(DP)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model history indexed by edges since the last reset edge (index 0 = reset state).
    int          n = 0;
    logic        mode_h [0:HMAX-1];
    logic [3:0]  addr_h [0:HMAX-1];
    logic [31:0] data_h [0:HMAX-1];
    logic [6:0]  seg_cap [0:7];
    logic        dp_cap [0:7];

    function automatic logic [6:0] enc(input int v);
        logic [6:0] t [0:15];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v & 15];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int dig, nibv, val, dpv;
        if (n == 0) begin
            chk("rst_addr", 32'(rd_addr), 0);
            chk("rst_seg", 32'(SEG), 32'h7F);
            chk("rst_an", 32'(AN), 32'hFF);
            chk("rst_dp", 32'(DP), 1);
        end else begin
            dig  = ((n - 1) / REFRESH_DIV) % DIGITS;
            val  = int'(data_h[n-1]);
            nibv = (val >> (4 * dig)) & 15;
            dpv  = (dig == 0 && mode_h[n]) ? 0 : 1;
`ifdef REG_VIEW_ADDR_SHOW_EN
            if (dig == DIGITS - 1) nibv = (int'(addr_h[n-1]) >> 4) & 15;
            if (dig == DIGITS - 2) begin
                nibv = int'(addr_h[n-1]) & 15;
                dpv  = 0;
            end
`endif
            chk("m_addr", 32'(rd_addr), 32'(addr_h[n]));
            chk("m_an", 32'(AN), 32'(8'hFF ^ (8'h01 << dig)));
            chk("m_seg", 32'(SEG), 32'(enc(nibv)));
            chk("m_dp", 32'(DP), 32'(dpv));
        end
    endtask

    task automatic tick();
        int r;
        @(posedge CLK);
        if (!rst) begin
            n = 0;
            addr_h[0] = 4'h0;
            data_h[0] = 32'h0;
            mode_h[0] = 1'b0;
        end else begin
            n++;
            if (n >= HMAX) begin
                $display("FAIL history_overflow n=%0d limit=%0d", n, HMAX);
                $fatal(1, "history overflow");
            end
            mode_h[n] = mode;
            data_h[n] = bank[addr_h[n-1]];
            if (!mode) begin
                addr_h[n] = sel;
            end else begin
                // Auto run of r edges advances the address once per full dwell from where it started.
                r = 0;
                while (n - r >= 1 && mode_h[n-r]) r++;
                addr_h[n] = 4'((int'(addr_h[n-r]) + r / HOLD_CYCLES) % 16);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic sweep();
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int d = 0; d < 8; d++) begin
                if (AN == (8'hFF ^ (8'h01 << d))) begin
                    seg_cap[d] = SEG;
                    dp_cap[d]  = DP;
                end
            end
        end
    endtask

    initial begin
        int found;
        int digits_exp [0:7];
        for (int i = 0; i < 16; i++) bank[i] = $urandom;
        bank[5] = 32'h89AB_CDEF;
        for (int d = 0; d < 8; d++) begin
            seg_cap[d] = 7'h7F;
            dp_cap[d]  = 1'b1;
        end

        rst = 1'b0;
        repeat (3) tick();
        chk("reset_seg", 32'(SEG), 32'h7F);
        chk("reset_an", 32'(AN), 32'hFF);
        chk("reset_dp", 32'(DP), 1);
        chk("reset_addr", 32'(rd_addr), 0);

        rst = 1'b1;
        found = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (AN == 8'hFE) found = 1;
        end
        chk("release_an_fe", 32'(found), 1);

        mode = 1'b0;
        sel  = 4'd5;
        tick();
        chk("manual_addr5", 32'(rd_addr), 5);
        sweep();
        digits_exp = '{15, 14, 13, 12, 11, 10, 9, 8};
`ifndef REG_VIEW_ADDR_SHOW_EN
        for (int d = 0; d < 8; d++) chk($sformatf("manual_digit%0d", d), 32'(seg_cap[d]), 32'(enc(digits_exp[d])));
        chk("manual_digit7_eight", 32'(seg_cap[7]), 32'h00);
`else
        for (int d = 0; d < 6; d++) chk($sformatf("manual_digit%0d", d), 32'(seg_cap[d]), 32'(enc(digits_exp[d])));
`endif

        sel = 4'd14;
        tick();
        chk("auto_start14", 32'(rd_addr), 14);
        mode = 1'b1;
        repeat (15) tick();
        chk("auto_hold14", 32'(rd_addr), 14);
        tick();
        chk("auto_to15", 32'(rd_addr), 15);
        repeat (16) tick();
        chk("auto_wrap0", 32'(rd_addr), 0);

        repeat (10) tick();
        mode = 1'b0;
        sel  = 4'd3;
        tick();
        chk("switch_addr3", 32'(rd_addr), 3);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("switch_hold3", 32'(rd_addr), 3);
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            sel = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) bank[$urandom_range(15)] = $urandom;
            tick();
        end

        mode  = 1'b1;
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            tick();
            if (AN == 8'hF7) found = 1;
        end
        chk("wait_digit3", 32'(found), 1);
        rst = 1'b0;
        tick();
        chk("midreset_seg", 32'(SEG), 32'h7F);
        chk("midreset_an", 32'(AN), 32'hFF);
        chk("midreset_dp", 32'(DP), 1);
        chk("midreset_addr", 32'(rd_addr), 0);
        rst = 1'b1;
        repeat (8) tick();

`ifdef REG_VIEW_ADDR_SHOW_EN
        mode = 1'b0;
        sel  = 4'd10;
        tick();
        sweep();
        chk("addr_digit7", 32'(seg_cap[7]), 32'(enc(0)));
        chk("addr_digit6", 32'(seg_cap[6]), 32'(enc(10)));
        chk("addr_digit6_dp", 32'(dp_cap[6]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_view_disp.md
REG_VIEW_DISP -- requirements
Module: reg_view_disp

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed seven-segment digits, range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: CLK cycles per digit slot, minimum 2.
REQ-003 Parameter ADDR_W, default 4: register-bank address width.
REQ-004 Parameter HOLD_CYCLES, default 50000000: auto-scan dwell per register in CLK cycles, minimum 2.
REQ-005 CLK  in  1  single system clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 mode  in  1  0 = manual select, 1 = auto-scan.
REQ-008 sel  in  ADDR_W  manual register address, from switches.
REQ-009 rd_data  in  32  register-bank read data, combinational from rd_addr.
REQ-010 rd_addr  out  ADDR_W  register-bank read address, registered.
REQ-011 SEG  out  7  segment drive, active-low, SEG[6:0] = g,f,e,d,c,b,a.
REQ-012 AN  out  DIGITS  digit enables, active-low, one-hot when active.
REQ-013 DP  out  1  decimal point, active-low.

Function
REQ-014 Manual mode: rd_addr SHALL equal sel registered, one cycle latency.
REQ-015 Auto mode: a dwell counter SHALL count 0..HOLD_CYCLES-1; on its terminal count rd_addr SHALL increment, wrapping from 2^ADDR_W-1 to 0.
REQ-016 Manual-to-auto transition: scanning SHALL start from the current rd_addr with the dwell counter cleared.
REQ-017 Auto-to-manual transition: rd_addr SHALL load sel on the next edge; the dwell counter SHALL clear.
REQ-018 Shadow register SHALL capture rd_data every cycle, so the displayed value lags rd_addr by one cycle.
REQ-019 Refresh counter SHALL count 0..REFRESH_DIV-1; on its terminal count the digit index SHALL advance, wrapping from DIGITS-1 to 0.
REQ-020 Digit i SHALL display the hex value of shadow[4i+3:4i].
REQ-021 Encoding SHALL be standard hex, active-low: 0=1000000, 8=0000000, A=0001000, F=0001110.
REQ-022 SEG, AN and DP SHALL be registered, one cycle after the digit index and shadow they reflect.
REQ-023 AN SHALL drive bit i low and all other bits high while digit i is active.
REQ-024 DP SHALL be 0 only while digit 0 is active and mode=1; otherwise DP SHALL be 1.
REQ-025 A mode change SHALL NOT disturb the refresh counter or digit index.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL set: rd_addr=0, shadow=0, refresh and dwell counters=0, digit index=0, SEG=1111111, AN all ones, DP=1.
REQ-027 On the first edge after rst returns to 1, digit 0 SHALL become active. Reset asserted mid-scan SHALL override all pending increments.

Configuration
REQ-028 Macro REG_VIEW_ADDR_SHOW_EN, when defined and DIGITS>=4: the top two digits SHALL show the zero-extended registered rd_addr in hex in place of shadow[31:24]. The digit showing the address low nibble SHALL have DP=0. REQ-024 still applies to digit 0.
REQ-029 With the macro undefined, all digits SHALL show shadow per REQ-020 and no address logic SHALL be present.

Verification
REQ-030 The bench SHALL use REFRESH_DIV=4, HOLD_CYCLES=16 and DIGITS=8 for the scenarios below.
REQ-031 Reset: hold rst=0 for 3 cycles -> SEG=1111111, AN=11111111, DP=1, rd_addr=0. After release, AN=11111110 within 2 cycles.
REQ-032 Manual read: mode=0, sel=5, rd_data=32'h89AB_CDEF -> rd_addr=5 next cycle. Over one full refresh sweep, digits 0..7 show F,E,D,C,B,A,9,8; digit 7 SEG=0000000.
REQ-033 Auto-scan wrap: mode=1 from rd_addr=14 -> rd_addr=15 after 16 cycles, then 0 after 32 cycles. DP=0 only while AN=11111110.
REQ-034 Mode switch mid-dwell: mode=1 for 10 cycles, then mode=0 with sel=3 -> rd_addr=3 on the next edge, with no further auto increments.
REQ-035 Reset mid-operation: assert rst=0 during a digit-3 slot -> all outputs return to REQ-026 values on that edge. With REG_VIEW_ADDR_SHOW_EN defined and rd_addr=10, digit 7 shows 0, digit 6 shows A with DP=0.
